// File: rtl/memory_access_stage.sv
// MEM-stage data-memory access unit: turns load/store control into a registered
// req/ready bus transaction, stalls the pipeline until completion and returns load data.
module memory_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid_M,
  input  logic                  i_MemToReg_M,
  input  logic                  i_MemWrite_M,
  input  logic                  i_Byte_M,
  input  logic [DATA_WIDTH-1:0] i_ALUResult_M,
  input  logic [DATA_WIDTH-1:0] i_WriteData_M,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_ReadData_M,
  output logic                  o_stall_M,
  output logic                  o_fault_M
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    fault_q, fault_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    isLoad_q, isLoad_d;
  logic                    isByte_q, isByte_d;
  logic [1:0]              off_q, off_d;

  logic                    access;
  logic                    misaligned;
  logic                    stall;
  logic                    misFault;
  logic [DATA_WIDTH-1:0]   laneShift;

  assign access     = i_valid_M & (i_MemToReg_M | i_MemWrite_M);
  assign misaligned = access & ~i_Byte_M & (i_ALUResult_M[1:0] != 2'b00);
  assign laneShift  = i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = 1'b0;
    cnt_d    = cnt_q;
    isLoad_d = isLoad_q;
    isByte_d = isByte_q;
    off_d    = off_q;
    stall    = 1'b0;
    misFault = 1'b0;

    case (state_q)
      IDLE: begin
        if (misaligned) begin
          misFault = 1'b1;
          rdata_d  = '0;
        end else if (access) begin
          stall    = 1'b1;
          state_d  = BUSY;
          req_d    = 1'b1;
          we_d     = i_MemWrite_M;
          addr_d   = {i_ALUResult_M[DATA_WIDTH-1:2], 2'b00};
          be_d     = i_Byte_M ? (4'b0001 << i_ALUResult_M[1:0]) : 4'b1111;
          wdata_d  = i_Byte_M ? {(DATA_WIDTH/8){i_WriteData_M[7:0]}} : i_WriteData_M;
          cnt_d    = '0;
          // A simultaneous store suppresses the load so no read data is captured
          isLoad_d = i_MemToReg_M & ~i_MemWrite_M;
          isByte_d = i_Byte_M;
          off_d    = i_ALUResult_M[1:0];
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (isLoad_q) begin
            rdata_d = isByte_q ? {{(DATA_WIDTH-8){1'b0}}, laneShift[7:0]} : i_mem_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          req_d   = 1'b0;
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
      isLoad_q <= 1'b0;
      isByte_q <= 1'b0;
      off_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
      isLoad_q <= isLoad_d;
      isByte_q <= isByte_d;
      off_q    <= off_d;
    end
  end

  // Combinational outputs are gated so nothing stalls or faults while reset is held
  assign o_stall_M    = stall & i_reset;
  assign o_fault_M    = (fault_q | misFault) & i_reset;
  assign o_mem_req    = req_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_be     = be_q;
  assign o_mem_wdata  = wdata_q;
  assign o_ReadData_M = rdata_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Table-driven bench for memory_access_stage: directed load/store vectors plus
// hand-written reset sequences.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ld, st, bt;
  logic [31:0] addr, wdata;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic        memReady;
  logic [31:0] memRdata;
  logic [31:0] readData;
  logic        stall, fault;

  int totalChecks  = 0;
  int passedChecks = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_valid_M     (valid),
    .i_MemToReg_M  (ld),
    .i_MemWrite_M  (st),
    .i_Byte_M      (bt),
    .i_ALUResult_M (addr),
    .i_WriteData_M (wdata),
    .o_mem_req     (memReq),
    .o_mem_we      (memWe),
    .o_mem_addr    (memAddr),
    .o_mem_be      (memBe),
    .o_mem_wdata   (memWdata),
    .i_mem_ready   (memReady),
    .i_mem_rdata   (memRdata),
    .o_ReadData_M  (readData),
    .o_stall_M     (stall),
    .o_fault_M     (fault)
  );

  typedef struct {
    string       name;
    logic        valid, ld, st, bt;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic        expIdleStall, expIdleFault;
    int          expBusy;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic        expWe, chkWdata;
    logic [31:0] expWdata, expRead;
    logic        expDoneFault;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passedChecks++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    int          busyCycles = 0;
    logic        stable = 1'b1;
    logic        finished = 1'b0;
    logic [31:0] firstAddr = '0, firstWdata = '0;
    logic [3:0]  firstBe = '0;
    logic        firstWe = 1'b0;

    @(negedge clk);
    valid = v.valid; ld = v.ld; st = v.st; bt = v.bt;
    addr = v.addr; wdata = v.wdata; memRdata = v.rdata;
    memReady = 1'b1;
    #1;
    checkOutput({v.name, " idleStall"}, 32'(stall), 32'(v.expIdleStall));
    checkOutput({v.name, " idleFault"}, 32'(fault), 32'(v.expIdleFault));

    for (int c = 0; c < 64 && !finished; c++) begin
      @(negedge clk);
      if (!stall) begin
        finished = 1'b1;
      end else begin
        if (busyCycles == 0) begin
          firstAddr = memAddr; firstBe = memBe; firstWe = memWe; firstWdata = memWdata;
        end else if (memAddr !== firstAddr || memBe !== firstBe ||
                     memWe !== firstWe || memWdata !== firstWdata) begin
          stable = 1'b0;
        end
        if (memReq !== 1'b1) stable = 1'b0;
        memReady = (busyCycles == v.waits);
        busyCycles++;
      end
    end
    if (!finished) $display("[TB] FAIL %s wait: stall never released", v.name);

    valid = 1'b0; memReady = 1'b0;
    #1;
    checkOutput({v.name, " busyCycles"}, 32'(busyCycles), 32'(v.expBusy));
    if (v.expBusy > 0) begin
      checkOutput({v.name, " addr"}, firstAddr, v.expAddr);
      checkOutput({v.name, " be"}, 32'(firstBe), 32'(v.expBe));
      checkOutput({v.name, " we"}, 32'(firstWe), 32'(v.expWe));
      checkOutput({v.name, " stable"}, 32'(stable), 32'd1);
      if (v.chkWdata) checkOutput({v.name, " wdata"}, firstWdata, v.expWdata);
    end
    checkOutput({v.name, " doneReq"}, 32'(memReq), 32'd0);
    checkOutput({v.name, " doneFault"}, 32'(fault), 32'(v.expDoneFault));
    checkOutput({v.name, " readData"}, readData, v.expRead);
  endtask

  initial begin
    vec_t rv;

    //            name          vl ld st bt addr          wdata         rdata        waits iS iF busy addr        be      we cW wdataExp     read         dF
    vecs[0]  = '{"wordLoad",    1, 1, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0,  1, 0, 1,  32'h100, 4'b1111, 0, 0, 32'h0,        32'hDEADBEEF, 0};
    vecs[1]  = '{"byteStore",   1, 0, 1, 1, 32'h203, 32'h5A,       32'h0,        3,  1, 0, 4,  32'h200, 4'b1000, 1, 1, 32'h5A5A5A5A, 32'hDEADBEEF, 0};
    vecs[2]  = '{"byteLoad2",   1, 1, 0, 1, 32'h102, 32'h0,        32'h11223344, 1,  1, 0, 2,  32'h100, 4'b0100, 0, 0, 32'h0,        32'h22,       0};
    vecs[3]  = '{"misLoad",     1, 1, 0, 0, 32'h101, 32'h0,        32'h0,        0,  0, 1, 0,  32'h0,   4'b0000, 0, 0, 32'h0,        32'h0,        0};
    vecs[4]  = '{"lateReady",   1, 1, 0, 1, 32'h003, 32'h0,        32'hAABBCCDD, 15, 1, 0, 16, 32'h0,   4'b1000, 0, 0, 32'h0,        32'hAA,       0};
    vecs[5]  = '{"timeout",     1, 1, 0, 0, 32'h400, 32'h0,        32'h0,        -1, 1, 0, 16, 32'h400, 4'b1111, 0, 0, 32'h0,        32'h0,        1};
    vecs[6]  = '{"byteLoad1",   1, 1, 0, 1, 32'h001, 32'h0,        32'h1234AB78, 0,  1, 0, 1,  32'h0,   4'b0010, 0, 0, 32'h0,        32'hAB,       0};
    vecs[7]  = '{"wordStore",   1, 0, 1, 0, 32'h304, 32'hCAFEF00D, 32'h0,        2,  1, 0, 3,  32'h304, 4'b1111, 1, 1, 32'hCAFEF00D, 32'hAB,       0};
    vecs[8]  = '{"ldAndSt",     1, 1, 1, 0, 32'h500, 32'h12345678, 32'hFFFFFFFF, 0,  1, 0, 1,  32'h500, 4'b1111, 1, 1, 32'h12345678, 32'hAB,       0};
    vecs[9]  = '{"noAccess",    1, 0, 0, 0, 32'h123, 32'h0,        32'h0,        0,  0, 0, 0,  32'h0,   4'b0000, 0, 0, 32'h0,        32'hAB,       0};
    vecs[10] = '{"bubbleLoad",  0, 1, 0, 0, 32'h600, 32'h0,        32'h0,        0,  0, 0, 0,  32'h0,   4'b0000, 0, 0, 32'h0,        32'hAB,       0};
    vecs[11] = '{"misStore",    1, 0, 1, 0, 32'h306, 32'h77,       32'h0,        0,  0, 1, 0,  32'h0,   4'b0000, 0, 0, 32'h0,        32'h0,        0};

    // Reset held with a load presented: everything must stay quiet
    rst_n = 1'b0; valid = 1'b1; ld = 1'b1; st = 1'b0; bt = 1'b0;
    addr = 32'h100; wdata = 32'h0; memReady = 1'b0; memRdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst req",   32'(memReq),   32'd0);
    checkOutput("rst we",    32'(memWe),    32'd0);
    checkOutput("rst addr",  memAddr,       32'd0);
    checkOutput("rst be",    32'(memBe),    32'd0);
    checkOutput("rst wdata", memWdata,      32'd0);
    checkOutput("rst read",  readData,      32'd0);
    checkOutput("rst stall", 32'(stall),    32'd0);
    checkOutput("rst fault", 32'(fault),    32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Reset dropped in the second BUSY cycle of a load
    @(negedge clk);
    valid = 1'b1; ld = 1'b1; st = 1'b0; bt = 1'b0; addr = 32'h600; memReady = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midRst busy1 req", 32'(memReq), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst req",   32'(memReq), 32'd0);
    checkOutput("midRst stall", 32'(stall),  32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    rv = '{"postRst", 1, 1, 0, 0, 32'h700, 32'h0, 32'h0BADCAFE, 1, 1, 0, 2, 32'h700, 4'b1111, 0, 0, 32'h0, 32'h0BADCAFE, 0};
    applyStimulus(rv);

    $display("[TB] %0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
